fifo_rr_arbiter: RTL and testbench



---
 rtl/fifo_rr_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready requesters.
// A grant is held for up to MAX_BURST transfers, or until an EOT-tagged word,
// so packets from one requester stay contiguous downstream.
module fifo_rr_arbiter #(
  parameter  int N         = 4,
  parameter  int DIN       = 16,
  parameter  int MAX_BURST = 1,
  parameter  int EOT       = 0,
  localparam int IW        = $clog2(N),
  localparam int CNTW      = $clog2(MAX_BURST+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       din_valid,
  output logic [N-1:0]       din_ready,
  input  logic [N*DIN-1:0]   din_data,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [IW+DIN-1:0]  dout_data
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d, ptr_q, ptr_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [N-1:0][DIN-1:0]   pay;
  logic [IW-1:0]           sel, cur;
  logic [IW:0]             scan;
  logic                    found, vld_raw, hs, eot;

  assign pay = din_data;

  // Next index after x, wrapping explicitly so non-power-of-two N works.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IW'(N-1)) ? '0 : x + 1'b1;
  endfunction

  // First valid requester scanning ptr, ptr+1, ... modulo N.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N)) scan = scan - (IW+1)'(N);
      if (!found && din_valid[scan[IW-1:0]]) begin
        found = 1'b1;
        sel   = scan[IW-1:0];
      end
    end
  end

  // Output mux: the locked owner in GRANT, the fresh selection in IDLE; gated by reset.
  always_comb begin
    cur        = (state_q == GRANT) ? owner_q : sel;
    vld_raw    = (state_q == GRANT) ? din_valid[owner_q] : found;
    dout_valid = vld_raw & ~rst;
    dout_data  = {cur, pay[cur]};
    hs         = dout_valid & dout_ready;
    eot        = (EOT != 0) & pay[cur][DIN-1];
    din_ready  = '0;
    for (int i = 0; i < N; i++)
      din_ready[i] = dout_ready & ~rst & (cur == IW'(i)) & ((state_q == GRANT) | vld_raw);
  end

  // Grant FSM: lock on backpressure or mid-burst, release on burst end, EOT or owner drop.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (found) begin
        if (hs && (MAX_BURST == 1 || eot)) begin
          ptr_d = wrap_inc(sel);
        end else begin
          state_d = GRANT;
          owner_d = sel;
          cnt_d   = hs ? CNTW'(1) : '0;
        end
      end
      GRANT: if (!din_valid[owner_q]) begin
        state_d = IDLE;
        ptr_d   = wrap_inc(owner_q);
      end else if (hs) begin
        if ((int'(cnt_q) + 1 == MAX_BURST) || eot) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: three configurations (N=4/MB=4, N=3/MB=1,
// N=4/MB=8/EOT) driven by a directed vector table, then random traffic
// checked against a behavioural model of the arbitration rules.
module tb_fifo_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]        vi[3];
  logic [3:0][15:0]  di[3];
  logic              ro[3];
  logic              vo[3];
  logic [17:0]       dout[3];
  logic [3:0]        rdy[3];
  logic [2:0]        rdyb;

  int nn[3] = '{4, 3, 4};
  int mb[3] = '{4, 1, 8};
  int eo[3] = '{0, 0, 1};

  fifo_rr_arbiter #(.N(4), .DIN(16), .MAX_BURST(4), .EOT(0)) u_a (
    .clk(clk), .rst(rst), .din_valid(vi[0]), .din_ready(rdy[0]), .din_data(di[0]),
    .dout_valid(vo[0]), .dout_ready(ro[0]), .dout_data(dout[0]));
  fifo_rr_arbiter #(.N(3), .DIN(16), .MAX_BURST(1), .EOT(0)) u_b (
    .clk(clk), .rst(rst), .din_valid(vi[1][2:0]), .din_ready(rdyb), .din_data(di[1][2:0]),
    .dout_valid(vo[1]), .dout_ready(ro[1]), .dout_data(dout[1]));
  fifo_rr_arbiter #(.N(4), .DIN(16), .MAX_BURST(8), .EOT(1)) u_c (
    .clk(clk), .rst(rst), .din_valid(vi[2]), .din_ready(rdy[2]), .din_data(di[2]),
    .dout_valid(vo[2]), .dout_ready(ro[2]), .dout_data(dout[2]));
  assign rdy[1] = {1'b0, rdyb};

  typedef struct {
    int        u;
    bit        r;
    bit [3:0]  v;
    bit        rd;
    bit [15:0] d0;
    bit        ev;
    bit [17:0] ed;
    bit [3:0]  er;
  } vec_t;
  vec_t tv[$];

  int nvec = 0, nerr = 0;

  // Behavioural model: owner (-1 = none), transfers so far in the grant, scan start.
  int m_own[3], m_cnt[3], m_ptr[3];
  bit [3:0] hsp[3];

  function automatic void addv(int u, bit r, bit [3:0] v, bit rd, bit [15:0] d0,
                               bit ev, bit [17:0] ed, bit [3:0] er);
    vec_t t;
    t = '{u, r, v, rd, d0, ev, ed, er};
    tv.push_back(t);
  endfunction

  function automatic void meval(int u, output bit ev, output bit [17:0] ed,
                                output bit [3:0] er, output int c);
    bit found;
    int j;
    found = 0;
    c = m_own[u];
    if (c < 0)
      for (int k = 0; k < nn[u]; k++) begin
        j = (m_ptr[u] + k) % nn[u];
        if (!found && vi[u][j[1:0]]) begin found = 1; c = j; end
      end
    ev = (c >= 0) && vi[u][c[1:0]] && !rst;
    er = '0;
    if (!rst && ro[u] && c >= 0 && (m_own[u] >= 0 || ev)) er[c[1:0]] = 1'b1;
    ed = '0;
    if (c >= 0) ed = {c[1:0], di[u][c[1:0]]};
  endfunction

  function automatic void mstep(int u, int c, bit ev);
    bit hs, e;
    hs = ev && ro[u];
    if (rst) begin m_own[u] = -1; m_cnt[u] = 0; m_ptr[u] = 0; return; end
    if (c < 0) return;
    e = (eo[u] != 0) && di[u][c[1:0]][15];
    if (m_own[u] < 0) begin
      if (hs && (mb[u] == 1 || e)) m_ptr[u] = (c + 1) % nn[u];
      else begin m_own[u] = c; m_cnt[u] = hs ? 1 : 0; end
    end else if (!vi[u][c[1:0]]) begin
      m_own[u] = -1; m_ptr[u] = (c + 1) % nn[u];
    end else if (hs) begin
      m_cnt[u]++;
      if (m_cnt[u] == mb[u] || e) begin m_own[u] = -1; m_ptr[u] = (c + 1) % nn[u]; end
    end
  endfunction

  task automatic check(string nm, int u, bit ev, bit [17:0] ed, bit [3:0] er);
    nvec++;
    if (vo[u] !== ev || (ev && dout[u] !== ed) || rdy[u] !== er) begin
      nerr++;
      $display("FAIL %s u%0d t=%0t: got valid=%0b data=%h ready=%b, want valid=%0b data=%h ready=%b",
               nm, u, $time, vo[u], dout[u], rdy[u], ev, ed, er);
    end
  endtask

  initial begin
    bit        ev;
    bit [17:0] ed;
    bit [3:0]  er;
    int        c;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin vi[u] = '0; ro[u] = 1'b0; di[u] = '0; end

    // Reset mid-burst (unit A: N=4, MB=4)
    addv(0, 1, 4'b0100, 1, 16'hBEEF, 0, 18'h0,     4'b0000);
    addv(0, 0, 4'b0100, 1, 16'hBEEF, 1, 18'h22222, 4'b0100);
    addv(0, 0, 4'b0100, 1, 16'hBEEF, 1, 18'h22222, 4'b0100);
    addv(0, 1, 4'b1111, 1, 16'hBEEF, 0, 18'h0,     4'b0000);
    addv(0, 0, 4'b1111, 1, 16'hBEEF, 1, 18'h0BEEF, 4'b0001);
    // Round-robin fairness (unit B: N=3, MB=1)
    addv(1, 1, 4'b0111, 1, 16'hBEEF, 0, 18'h0,     4'b0000);
    for (int k = 0; k < 2; k++) begin
      addv(1, 0, 4'b0111, 1, 16'hBEEF, 1, 18'h0BEEF, 4'b0001);
      addv(1, 0, 4'b0111, 1, 16'hBEEF, 1, 18'h11111, 4'b0010);
      addv(1, 0, 4'b0111, 1, 16'hBEEF, 1, 18'h22222, 4'b0100);
    end
    // Backpressure stability (unit B)
    addv(1, 1, 4'b0001, 0, 16'hA5A5, 0, 18'h0,     4'b0000);
    addv(1, 0, 4'b0001, 0, 16'hA5A5, 1, 18'h0A5A5, 4'b0000);
    addv(1, 0, 4'b0011, 0, 16'hA5A5, 1, 18'h0A5A5, 4'b0000);
    addv(1, 0, 4'b0011, 0, 16'hA5A5, 1, 18'h0A5A5, 4'b0000);
    addv(1, 0, 4'b0011, 1, 16'hA5A5, 1, 18'h0A5A5, 4'b0001);
    addv(1, 0, 4'b0010, 1, 16'hA5A5, 1, 18'h11111, 4'b0010);
    // EOT release (unit C: MB=8, EOT=1)
    addv(2, 1, 4'b0011, 1, 16'h0001, 0, 18'h0,     4'b0000);
    addv(2, 0, 4'b0011, 1, 16'h0001, 1, 18'h00001, 4'b0001);
    addv(2, 0, 4'b0011, 1, 16'h0002, 1, 18'h00002, 4'b0001);
    addv(2, 0, 4'b0011, 1, 16'h8003, 1, 18'h08003, 4'b0001);
    addv(2, 0, 4'b0010, 1, 16'h0000, 1, 18'h11111, 4'b0010);
    // Owner drop (unit A): one dead cycle, owner keeps ready, then ch2 skipping idle ch1
    addv(0, 1, 4'b0101, 1, 16'h0001, 0, 18'h0,     4'b0000);
    addv(0, 0, 4'b0101, 1, 16'h0001, 1, 18'h00001, 4'b0001);
    addv(0, 0, 4'b0100, 1, 16'h0001, 0, 18'h0,     4'b0001);
    addv(0, 0, 4'b0100, 1, 16'h0001, 1, 18'h22222, 4'b0100);

    foreach (tv[k]) begin
      @(posedge clk); #1;
      rst = tv[k].r;
      for (int u = 0; u < 3; u++) begin
        vi[u] = '0; ro[u] = 1'b0; di[u] = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      end
      vi[tv[k].u]    = tv[k].v;
      ro[tv[k].u]    = tv[k].rd;
      di[tv[k].u][0] = tv[k].d0;
      @(negedge clk);
      check($sformatf("vec%0d", k), tv[k].u, tv[k].ev, tv[k].ed, tv[k].er);
    end

    // Random traffic against the model, with occasional asynchronous reset pulses.
    @(posedge clk); #1;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      vi[u] = '0; ro[u] = 1'b0; hsp[u] = '0;
      m_own[u] = -1; m_cnt[u] = 0; m_ptr[u] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      for (int u = 0; u < 3; u++) begin
        for (int i = 0; i < nn[u]; i++) begin
          if ((vi[u][i] && hsp[u][i]) || !vi[u][i]) begin
            vi[u][i] = vi[u][i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            di[u][i] = 16'($urandom);
            di[u][i][15] = ($urandom_range(0, 3) == 0);
          end
        end
        ro[u] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        meval(u, ev, ed, er, c);
        check("rand", u, ev, ed, er);
        mstep(u, c, ev);
        hsp[u] = vi[u] & rdy[u];
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
